multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multi-cycle control sequencer for the RV32I core. Replaces per-instruction combinational decode with an FSM that steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and shares a single memory port between instruction fetch and data access through a req/ready handshake. It drives the mux selects, write enables and ALU operation class for the shared datapath. It also counts retired instructions and traps on illegal opcodes.

## Interface
- No parameters. Opcode encodings are fixed RV32I: R 0110011, I-ALU 0010011, LW 0000011, SW 0100011, BR 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  7  IR[6:0], valid from DECODE onward
- mem_ready  in  1  memory completes the current access on this edge
- branch_taken  in  1  branch comparator result, sampled in EXEC
- mem_req  out  1  memory access request
- mem_we  out  1  1 = store, valid while mem_req
- ir_write  out  1  latch IR and old_pc
- pc_write  out  1  update PC
- pc_src  out  2  00 PC+4, 01 old_pc+imm, 10 ALU result & ~1
- alu_src_a  out  2  00 rs1, 01 old_pc, 10 zero
- alu_src_b  out  1  0 rs2, 1 imm
- alu_op  out  2  00 add, 01 compare, 10 funct-decoded, 11 pass B
- reg_write  out  1  register file write enable
- mem_to_reg  out  2  00 ALUOut, 01 memory data, 10 old_pc+4
- illegal  out  1  sticky trap flag
- retire  out  1  one-cycle pulse per completed instruction
- instret  out  32  retired-instruction count
- state  out  3  FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 5

## Operation
- FETCH: mem_req=1, mem_we=0. Hold until mem_ready=1. On the ready edge, ir_write=1, pc_write=1 and pc_src=00, then go to DECODE.
- DECODE: latch opcode into internal op_q. A legal opcode goes to EXEC. Any other opcode goes to TRAP. No enables are asserted.
- EXEC: decode is from op_q only.
  - R: a=00, b=0, alu_op=10, go to WB.
  - I-ALU: a=00, b=1, alu_op=10, go to WB.
  - LUI: b=1, alu_op=11, go to WB.
  - AUIPC: a=01, b=1, alu_op=00, go to WB.
  - LW/SW: a=00, b=1, alu_op=00, go to MEM.
  - BR: a=00, b=0, alu_op=01. pc_write=branch_taken, pc_src=01. Retire and go to FETCH.
  - JAL: pc_write=1, pc_src=01, go to WB.
  - JALR: a=00, b=1, alu_op=00, pc_write=1, pc_src=10, go to WB.
- MEM: mem_req=1, mem_we=(op_q==SW). Hold until mem_ready=1. On the ready edge, SW retires and goes to FETCH, LW goes to WB.
- WB: reg_write=1 for one cycle. mem_to_reg is 01 for LW, 10 for JAL/JALR, 00 otherwise. Retire and go to FETCH.
- TRAP: illegal=1. All enables stay 0, including mem_req. The FSM stays in TRAP until reset.
- retire pulses in the final cycle of each instruction. instret increments on that same edge and wraps from 0xFFFFFFFF to 0.
- Any output not listed for a state is 0.

## Timing
- Reset (rst_n low, asynchronous): state=FETCH, op_q=0, instret=0, illegal=0. Every output is forced to 0 while rst_n is low, including mem_req. mem_req first asserts in the first cycle after rst_n deasserts.
- Reset asserted mid-instruction, including while mem_req is pending, aborts immediately. No write enable may be high during reset.
- Outputs are combinational from state, op_q, mem_ready and branch_taken, with no registered delay.
- ir_write and the FETCH pc_write are gated by mem_ready. The MEM-state exit is also gated by mem_ready.
- Handshake rules:
  - Once raised, mem_req stays high and mem_we stays stable until mem_ready is sampled high.
  - mem_ready is ignored outside FETCH and MEM.
- Latency with zero-wait memory (mem_ready=1 in the first request cycle):
  - BR: 3 cycles.
  - R, I-ALU, LUI, AUIPC, SW, JAL, JALR: 4 cycles.
  - LW: 5 cycles.
  - Each wait cycle adds one.
- A change on the opcode input after DECODE has no effect on the current instruction.

## Test plan
- Reset, then R-type 0110011 with mem_ready tied 1 -> states 0,1,2,4,0. reg_write=1 only in WB. retire once, instret=1.
- LW with 2 wait cycles in FETCH and 1 in MEM -> mem_req high for 3 FETCH cycles and 2 MEM cycles, mem_we=0. mem_to_reg=01 in WB. Total 8 cycles.
- SW -> mem_we=1 only in MEM. No WB state, reg_write never 1. retire at the MEM ready edge.
- BR with branch_taken=0, then BR with branch_taken=1 -> pc_write is 0 then 1 in EXEC with pc_src=01. Each instruction takes 3 cycles.
- Opcode 1111111 -> TRAP after DECODE. illegal=1, mem_req=0 indefinitely. rst_n low clears illegal and returns state to FETCH.
- Preload instret near wrap by running 0xFFFFFFFF retirements (forced), then one more -> instret=0. rst_n pulsed during a MEM wait -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I control sequencer sharing one memory port
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives datapath selects.
module multicycle_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  opcode,
   input  logic        mem_ready,
   input  logic        branch_taken,
   output logic        mem_req,
   output logic        mem_we,
   output logic        ir_write,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic [1:0]  alu_src_a,
   output logic        alu_src_b,
   output logic [1:0]  alu_op,
   output logic        reg_write,
   output logic [1:0]  mem_to_reg,
   output logic        illegal,
   output logic        retire,
   output logic [31:0] instret,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   state_t      state_q, state_d;
   logic [6:0]  op_q;
   logic [31:0] instret_q;

   logic       req_d, we_d, irw_d, pcw_d, sb_d, rw_d, ret_d;
   logic [1:0] pcs_d, sa_d, aop_d, m2r_d;

   function automatic logic is_legal(input logic [6:0] op);
      case (op)
         OP_R, OP_I, OP_LW, OP_SW, OP_BR,
         OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal = 1'b1;
         default:                           is_legal = 1'b0;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         op_q      <= 7'd0;
         instret_q <= 32'd0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE)
            op_q <= opcode;
         if (ret_d)
            instret_q <= instret_q + 32'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      req_d   = 1'b0;
      we_d    = 1'b0;
      irw_d   = 1'b0;
      pcw_d   = 1'b0;
      pcs_d   = 2'b00;
      sa_d    = 2'b00;
      sb_d    = 1'b0;
      aop_d   = 2'b00;
      rw_d    = 1'b0;
      m2r_d   = 2'b00;
      ret_d   = 1'b0;
      case (state_q)
         S_FETCH: begin
            req_d = 1'b1;
            if (mem_ready) begin
               irw_d   = 1'b1;
               pcw_d   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: state_d = is_legal(opcode) ? S_EXEC : S_TRAP;
         S_EXEC: begin
            // EXEC decodes only the latched opcode so later IR changes cannot leak in
            case (op_q)
               OP_R: begin
                  aop_d   = 2'b10;
                  state_d = S_WB;
               end
               OP_I: begin
                  sb_d    = 1'b1;
                  aop_d   = 2'b10;
                  state_d = S_WB;
               end
               OP_LUI: begin
                  sb_d    = 1'b1;
                  aop_d   = 2'b11;
                  state_d = S_WB;
               end
               OP_AUIPC: begin
                  sa_d    = 2'b01;
                  sb_d    = 1'b1;
                  state_d = S_WB;
               end
               OP_LW, OP_SW: begin
                  sb_d    = 1'b1;
                  state_d = S_MEM;
               end
               OP_BR: begin
                  aop_d   = 2'b01;
                  pcw_d   = branch_taken;
                  pcs_d   = 2'b01;
                  ret_d   = 1'b1;
                  state_d = S_FETCH;
               end
               OP_JAL: begin
                  pcw_d   = 1'b1;
                  pcs_d   = 2'b01;
                  state_d = S_WB;
               end
               OP_JALR: begin
                  sb_d    = 1'b1;
                  pcw_d   = 1'b1;
                  pcs_d   = 2'b10;
                  state_d = S_WB;
               end
               default: state_d = S_TRAP;
            endcase
         end
         S_MEM: begin
            req_d = 1'b1;
            we_d  = (op_q == OP_SW);
            if (mem_ready) begin
               if (op_q == OP_SW) begin
                  ret_d   = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            rw_d    = 1'b1;
            ret_d   = 1'b1;
            state_d = S_FETCH;
            if (op_q == OP_LW)
               m2r_d = 2'b01;
            else if (op_q == OP_JAL || op_q == OP_JALR)
               m2r_d = 2'b10;
         end
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_FETCH;
      endcase
   end

   // Outputs are gated by rst_n so nothing, mem_req included, is high during reset
   assign mem_req    = rst_n & req_d;
   assign mem_we     = rst_n & we_d;
   assign ir_write   = rst_n & irw_d;
   assign pc_write   = rst_n & pcw_d;
   assign pc_src     = rst_n ? pcs_d : 2'b00;
   assign alu_src_a  = rst_n ? sa_d  : 2'b00;
   assign alu_src_b  = rst_n & sb_d;
   assign alu_op     = rst_n ? aop_d : 2'b00;
   assign reg_write  = rst_n & rw_d;
   assign mem_to_reg = rst_n ? m2r_d : 2'b00;
   assign retire     = rst_n & ret_d;
   assign illegal    = rst_n & (state_q == S_TRAP);
   assign instret    = rst_n ? instret_q : 32'd0;
   assign state      = rst_n ? state_q : 3'd0;

endmodule
